// File: rtl/cpu_fetch.sv
// cpu_fetch: instruction-fetch stage feeding the control decoder.
// Holds the PC, fetches one 32-bit word at a time over a req/ready
// handshake, presents it until the datapath acks, then resolves the next PC
// from the decoded branch signals and the ALU zero flag. HALT stops fetch
// until reset.
module cpu_fetch #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,   // bits [1:0] must be 0
    parameter logic [10:0]       HALT_OPC = 11'b11111111111
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_ack,
    input  logic              Branch,
    input  logic              BranchZero,
    input  logic              BranchNonZero,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [31:0]       inst_nxt;
    logic [ADDR_W-1:0] b_off;
    logic [ADDR_W-1:0] cb_off;
    logic [ADDR_W-1:0] br_off;
    logic              taken;
    logic              is_halt;

    // Branch target arithmetic: word offsets sign-extended and scaled to bytes.
    always_comb begin
        b_off   = {{(ADDR_W-28){inst[25]}}, inst[25:0], 2'b00};
        cb_off  = {{(ADDR_W-21){inst[23]}}, inst[23:5], 2'b00};
        // Branch has priority for the offset when several branch inputs are set.
        br_off  = Branch ? b_off : cb_off;
        taken   = Branch | (BranchZero & alu_zero) | (BranchNonZero & ~alu_zero);
        is_halt = (inst[31:21] == HALT_OPC);
    end

    // State, PC and instruction registers; reset wins over any handshake.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            inst  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            inst  <= inst_nxt;
        end
    end

    // Next-state, next-PC and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_nxt  = state;
        pc_nxt     = pc;
        inst_nxt   = inst;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        halted     = 1'b0;
        unique case (state)
            S_FETCH: begin
                // No request is shown while reset is held, so memory never
                // sees a handshake that the reset edge would discard.
                imem_req = ~reset;
                if (imem_ready) begin
                    inst_nxt  = imem_rdata;
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                inst_valid = 1'b1;
                if (inst_ack) begin
                    if (is_halt) begin
                        // HALT freezes the PC at its own address.
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt    = taken ? pc + br_off : pc + ADDR_W'(4);
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed scenarios plus a randomized
// instruction stream checked against a PC model computed with plain
// signed arithmetic on the branch immediates.
module tb_cpu_fetch;

    localparam int          ADDR_W = 64;
    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ack;
    logic        br, bz, bnz, alu_zero;
    logic [63:0] pc;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    logic [63:0] m_pc;

    cpu_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RST_PC), .HALT_OPC(11'h7FF)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ack     (inst_ack),
        .Branch       (br),
        .BranchZero   (bz),
        .BranchNonZero(bnz),
        .alu_zero     (alu_zero),
        .pc           (pc),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference next-PC: offsets taken as signed word counts times four.
    function automatic logic [63:0] ref_next(input logic [63:0] cur, input logic [31:0] w,
                                             input logic b, input logic z_br, input logic nz_br,
                                             input logic z);
        logic [25:0] i26;
        logic [18:0] i19;
        longint      off;
        i26 = w[25:0];
        i19 = w[23:5];
        if (b) off = longint'($signed(i26)) * 4;
        else   off = longint'($signed(i19)) * 4;
        if (b || (z_br && z) || (nz_br && !z)) return cur + off;
        return cur + 64'd4;
    endfunction

    function automatic logic [31:0] mk_b(input longint imm);
        logic [63:0] v;
        v = imm;
        return {6'b000101, v[25:0]};
    endfunction

    function automatic logic [31:0] mk_cb(input longint imm);
        logic [63:0] v;
        v = imm;
        return {8'b10110100, v[18:0], 5'd0};
    endfunction

    // Offer word w after wait_cycles of ready=0; stray acks are ignored in FETCH.
    task automatic fetch(input logic [31:0] w, input int wait_cycles);
        imem_ready = 1'b0;
        repeat (wait_cycles) begin
            imem_rdata = $urandom;
            inst_ack   = 1'($urandom);
            step();
        end
        inst_ack   = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = w;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
    endtask

    // Ack the current word after wait_cycles; stray readys are ignored in EXEC.
    task automatic ack(input logic [31:0] w, input logic b, input logic z_br,
                       input logic nz_br, input logic z, input int wait_cycles);
        inst_ack = 1'b0;
        repeat (wait_cycles) begin
            imem_ready = 1'($urandom);
            {br, bz, bnz, alu_zero} = 4'($urandom);
            step();
        end
        imem_ready = 1'b0;
        inst_ack   = 1'b1;
        br = b; bz = z_br; bnz = nz_br; alu_zero = z;
        step();
        inst_ack = 1'b0;
        {br, bz, bnz, alu_zero} = 4'b0;
        if (w[31:21] != 11'h7FF) m_pc = ref_next(m_pc, w, b, z_br, nz_br, z);
    endtask

    // Move the PC to target with a single B instruction.
    task automatic goto(input logic [63:0] target);
        logic [31:0] w;
        w = mk_b(longint'(target - m_pc) >>> 2);
        fetch(w, 0);
        ack(w, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1234_5678; inst_ack = 1'b0;
        {br, bz, bnz, alu_zero} = 4'b0;
        step();
        step();
        m_pc = RST_PC;
        n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req_low: imem_req=%b expected 0", imem_req); else n_pass++;
        n_total++; if (pc !== RST_PC) $display("FAIL rst_pc: pc=%h expected %h", pc, RST_PC); else n_pass++;
        n_total++; if (inst_valid !== 1'b0 || halted !== 1'b0 || inst !== 32'h0)
            $display("FAIL rst_state: inst_valid=%b halted=%b inst=%h expected 0/0/0", inst_valid, halted, inst); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL rst_first_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RST_PC); else n_pass++;
        step();
        imem_ready = 1'b0;
        n_total++; if (inst_valid !== 1'b1 || inst !== 32'h1234_5678 || imem_req !== 1'b0)
            $display("FAIL rst_first_inst: valid=%b inst=%h req=%b expected 1/12345678/0", inst_valid, inst, imem_req); else n_pass++;
        ack(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        n_total++; if (pc !== 64'h104) $display("FAIL rst_seq_pc: pc=%h expected 104", pc); else n_pass++;
    endtask

    task automatic test_sequential();
        goto(64'h0);
        n_total++; if (pc !== 64'h0) $display("FAIL seq_goto0: pc=%h expected 0", pc); else n_pass++;
        fetch(32'h8B02_0020, 0);
        n_total++; if (inst !== 32'h8B02_0020 || inst_valid !== 1'b1)
            $display("FAIL seq_add_inst: inst=%h valid=%b expected 8b020020/1", inst, inst_valid); else n_pass++;
        ack(32'h8B02_0020, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        n_total++; if (pc !== 64'h4 || imem_req !== 1'b1 || imem_addr !== 64'h4 || inst_valid !== 1'b0)
            $display("FAIL seq_next: pc=%h req=%b addr=%h valid=%b expected 4/1/4/0", pc, imem_req, imem_addr, inst_valid); else n_pass++;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_rdata = $urandom;
            step();
            n_total++; if (imem_req !== 1'b1 || imem_addr !== 64'h4 || inst_valid !== 1'b0)
                $display("FAIL seq_stall%0d: req=%b addr=%h valid=%b expected 1/4/0", i, imem_req, imem_addr, inst_valid); else n_pass++;
        end
        fetch(32'hAA00_0004, 0);
        n_total++; if (inst !== 32'hAA00_0004) $display("FAIL seq_after_stall: inst=%h expected aa000004", inst); else n_pass++;
        ack(32'hAA00_0004, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_branches();
        logic [31:0] w;
        goto(64'h40);
        w = mk_b(-2);
        fetch(w, 0); ack(w, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        n_total++; if (pc !== 64'h38) $display("FAIL br_b_back: pc=%h expected 38", pc); else n_pass++;
        goto(64'h40);
        w = mk_cb(3);
        fetch(w, 1); ack(w, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        n_total++; if (pc !== 64'h4C) $display("FAIL br_cbz_taken: pc=%h expected 4c", pc); else n_pass++;
        goto(64'h40);
        fetch(w, 0); ack(w, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        n_total++; if (pc !== 64'h44) $display("FAIL br_cbz_not: pc=%h expected 44", pc); else n_pass++;
        goto(64'h40);
        fetch(w, 0); ack(w, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        n_total++; if (pc !== 64'h4C) $display("FAIL br_cbnz_taken: pc=%h expected 4c", pc); else n_pass++;
        goto(64'h40);
        fetch(w, 0); ack(w, 1'b0, 1'b0, 1'b1, 1'b1, 0);
        n_total++; if (pc !== 64'h44) $display("FAIL br_cbnz_not: pc=%h expected 44", pc); else n_pass++;
        // B offset 5 words with CB field reading +0: Branch must pick imm26.
        goto(64'h40);
        w = mk_b(5);
        fetch(w, 0); ack(w, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        n_total++; if (pc !== 64'h54) $display("FAIL br_multi: pc=%h expected 54", pc); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        goto(64'h0);
        w = mk_b(-1);
        fetch(w, 0); ack(w, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        n_total++; if (pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL wrap_down: pc=%h addr=%h expected fffffffffffffffc", pc, imem_addr); else n_pass++;
        fetch(32'h8B02_0020, 0); ack(32'h8B02_0020, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        n_total++; if (pc !== 64'h0) $display("FAIL wrap_up: pc=%h expected 0", pc); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [3:0]  f;
        for (int i = 0; i < 60; i++) begin
            do w = $urandom; while (w[31:21] == 11'h7FF);
            f = 4'($urandom);
            fetch(w, int'($urandom_range(0, 3)));
            n_total++; if (inst !== w || inst_valid !== 1'b1 || imem_req !== 1'b0)
                $display("FAIL rnd_inst%0d: inst=%h valid=%b req=%b expected %h/1/0", i, inst, inst_valid, imem_req, w); else n_pass++;
            ack(w, f[0], f[1], f[2], f[3], int'($urandom_range(0, 3)));
            n_total++; if (pc !== m_pc || imem_addr !== m_pc || imem_req !== 1'b1 || inst_valid !== 1'b0)
                $display("FAIL rnd_pc%0d: pc=%h addr=%h req=%b valid=%b expected %h/%h/1/0", i, pc, imem_addr, imem_req, inst_valid, m_pc, m_pc); else n_pass++;
        end
    endtask

    task automatic test_halt();
        logic [63:0] hpc;
        goto(64'h200);
        hpc = m_pc;
        fetch(32'hFFE0_0000, 0);
        n_total++; if (inst !== 32'hFFE0_0000 || inst_valid !== 1'b1)
            $display("FAIL halt_present: inst=%h valid=%b expected ffe00000/1", inst, inst_valid); else n_pass++;
        ack(32'hFFE0_0000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        n_total++; if (halted !== 1'b1 || pc !== hpc || inst_valid !== 1'b0)
            $display("FAIL halt_enter: halted=%b pc=%h valid=%b expected 1/%h/0", halted, pc, inst_valid, hpc); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            imem_ready = 1'b1; imem_rdata = $urandom; inst_ack = 1'($urandom); br = 1'b1;
            step();
            n_total++; if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== hpc || inst_valid !== 1'b0)
                $display("FAIL halt_hold%0d: req=%b halted=%b pc=%h valid=%b expected 0/1/%h/0", i, imem_req, halted, pc, inst_valid, hpc); else n_pass++;
        end
        imem_ready = 1'b0; inst_ack = 1'b0; br = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_pc = RST_PC;
        #1;
        n_total++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC)
            $display("FAIL halt_exit: halted=%b req=%b addr=%h expected 0/1/%h", halted, imem_req, imem_addr, RST_PC); else n_pass++;
        fetch(32'h9100_0421, 0);
        n_total++; if (inst !== 32'h9100_0421 || inst_valid !== 1'b1)
            $display("FAIL halt_refetch: inst=%h valid=%b expected 91000421/1", inst, inst_valid); else n_pass++;
        ack(32'h9100_0421, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        // Reset coincident with an accepted fetch: the word must be dropped.
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL mid_fetch_req: imem_req=%b expected 0", imem_req); else n_pass++;
        step();
        reset = 1'b0; imem_ready = 1'b0;
        m_pc = RST_PC;
        #1;
        n_total++; if (inst !== 32'h0 || inst_valid !== 1'b0 || pc !== RST_PC || imem_req !== 1'b1)
            $display("FAIL mid_fetch: inst=%h valid=%b pc=%h req=%b expected 0/0/%h/1", inst, inst_valid, pc, imem_req, RST_PC); else n_pass++;
        // Reset coincident with a taken-branch ack: next_pc must be discarded.
        w = mk_b(16);
        fetch(w, 0);
        inst_ack = 1'b1; br = 1'b1; reset = 1'b1;
        step();
        inst_ack = 1'b0; br = 1'b0; reset = 1'b0;
        #1;
        n_total++; if (pc !== RST_PC || inst_valid !== 1'b0 || inst !== 32'h0 || imem_req !== 1'b1)
            $display("FAIL mid_exec: pc=%h valid=%b inst=%h req=%b expected %h/0/0/1", pc, inst_valid, inst, imem_req, RST_PC); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; inst_ack = 1'b0;
        br = 1'b0; bz = 1'b0; bnz = 1'b0; alu_zero = 1'b0;
        m_pc = RST_PC;
        test_reset();
        test_sequential();
        test_branches();
        test_wrap();
        test_random();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
